// File: rtl/id_operand_issue.sv
// Decode-to-execute operand issue stage: resolves NUM_SRC operands from zero, register file,
// immediate or the youngest matching forwarding stage, with load-use stall and an ID/EX latch.
module id_operand_issue #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned OP_W       = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              in_exop,
    input  logic [NUM_SRC*REG_AW-1:0]    in_src_addr,
    input  logic [NUM_SRC*2-1:0]         in_src_sel,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [DATA_W-1:0]            in_offset,
    input  logic [REG_AW-1:0]            in_dest,

    output logic [NUM_SRC*REG_AW-1:0]    rf_raddr,
    input  logic [NUM_SRC*DATA_W-1:0]    rf_rdata,

    input  logic [FWD_STAGES-1:0]        fwd_we,
    input  logic [FWD_STAGES*REG_AW-1:0] fwd_dest,
    input  logic [FWD_STAGES-1:0]        fwd_avail,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,

    input  logic                         flush,

    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OP_W-1:0]              out_exop,
    output logic [NUM_SRC*DATA_W-1:0]    out_src,
    output logic [DATA_W-1:0]            out_offset,
    output logic [REG_AW-1:0]            out_dest,

    output logic                         hazard,
    output logic [CNT_W-1:0]             stall_cnt,
    input  logic                         cnt_clr
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [NUM_SRC*DATA_W-1:0] res_src;
    logic [NUM_SRC-1:0]        src_haz;
    logic                      capture;

    assign rf_raddr = in_src_addr;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_AW-1:0] addr;
        logic [1:0]        sel;
        logic [DATA_W-1:0] val;
        logic              haz;
        logic              hit;

        assign addr = in_src_addr[gi*REG_AW +: REG_AW];
        assign sel  = in_src_sel[gi*2 +: 2];

        always_comb begin
            val = '0;
            haz = 1'b0;
            hit = 1'b0;
            case (sel)
                2'b01: begin
                    if (addr != '0) begin
                        val = rf_rdata[gi*DATA_W +: DATA_W];
                        // First hit in age order wins; an unavailable younger hit still blocks
                        // older stages so stale data is never forwarded.
                        for (int j = 0; j < FWD_STAGES; j++) begin
                            if (!hit && fwd_we[j] && (fwd_dest[j*REG_AW +: REG_AW] == addr)) begin
                                hit = 1'b1;
                                if (fwd_avail[j]) begin
                                    val = fwd_data[j*DATA_W +: DATA_W];
                                end else begin
                                    haz = 1'b1;
                                end
                            end
                        end
                    end
                end
                2'b10:   val = in_imm;
                default: val = '0;
            endcase
        end

        assign res_src[gi*DATA_W +: DATA_W] = val;
        assign src_haz[gi]                  = haz;
    end

    assign hazard   = in_valid && (|src_haz);
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    logic                      valid_q, valid_d;
    logic [OP_W-1:0]           exop_q, exop_d;
    logic [NUM_SRC*DATA_W-1:0] src_q, src_d;
    logic [DATA_W-1:0]         offset_q, offset_d;
    logic [REG_AW-1:0]         dest_q, dest_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    always_comb begin
        valid_d  = valid_q;
        exop_d   = exop_q;
        src_d    = src_q;
        offset_d = offset_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;

        // Flush wins over both capture and hold; payload is left as is.
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            exop_d   = in_exop;
            src_d    = res_src;
            offset_d = in_offset;
            dest_d   = in_dest;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hazard && !flush && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            exop_q   <= '0;
            src_q    <= '0;
            offset_q <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            exop_q   <= exop_d;
            src_q    <= src_d;
            offset_q <= offset_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_exop   = exop_q;
    assign out_src    = src_q;
    assign out_offset = offset_q;
    assign out_dest   = dest_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_operand_issue.sv
// Directed self-checking bench for id_operand_issue (2 sources, 2 forwarding stages, 4-bit counter).
module tb_id_operand_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_exop;
    logic [9:0]  in_src_addr;
    logic [3:0]  in_src_sel;
    logic [31:0] in_imm;
    logic [31:0] in_offset;
    logic [4:0]  in_dest;
    logic [9:0]  rf_raddr;
    logic [63:0] rf_rdata;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_dest;
    logic [1:0]  fwd_avail;
    logic [63:0] fwd_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exop;
    logic [63:0] out_src;
    logic [31:0] out_offset;
    logic [4:0]  out_dest;
    logic        hazard;
    logic [3:0]  stall_cnt;
    logic        cnt_clr;

    int checks = 0;
    int errors = 0;

    id_operand_issue #(
        .DATA_W(32), .REG_AW(5), .NUM_SRC(2), .FWD_STAGES(2), .OP_W(8), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_exop(in_exop),
        .in_src_addr(in_src_addr), .in_src_sel(in_src_sel), .in_imm(in_imm),
        .in_offset(in_offset), .in_dest(in_dest),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_avail(fwd_avail), .fwd_data(fwd_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_exop(out_exop), .out_src(out_src),
        .out_offset(out_offset), .out_dest(out_dest),
        .hazard(hazard), .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        in_valid = 0; in_exop = '0; in_src_addr = '0; in_src_sel = '0; in_imm = '0;
        in_offset = '0; in_dest = '0; rf_rdata = '0; fwd_we = '0; fwd_dest = '0;
        fwd_avail = '0; fwd_data = '0; flush = 0; out_ready = 1; cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_src !== 64'h0) begin errors++; $display("FAIL reset_src: got %h want 0", out_src); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        checks++; if ({out_exop, out_offset, out_dest} !== 45'h0) begin errors++; $display("FAIL reset_payload: got %h want 0", {out_exop, out_offset, out_dest}); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        in_valid = 1; in_exop = 8'h0D; in_src_addr = {5'd0, 5'd3}; in_src_sel = {2'b10, 2'b01};
        rf_rdata = {32'h0, 32'h0000_1234}; in_imm = 32'h0000_00FF; in_offset = 32'h10; in_dest = 5'd4;
        #1;
        checks++; if (rf_raddr !== 10'({5'd0, 5'd3})) begin errors++; $display("FAIL basic_raddr: got %h want %h", rf_raddr, {5'd0, 5'd3}); end
        checks++; if ({in_ready, hazard} !== 2'b10) begin errors++; $display("FAIL basic_ready: got %b want 10", {in_ready, hazard}); end
        @(negedge clk);
        idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_src !== {32'hFF, 32'h1234}) begin errors++; $display("FAIL basic_src: got %h want %h", out_src, {32'hFF, 32'h1234}); end
        checks++; if ({out_exop, out_offset, out_dest} !== {8'h0D, 32'h10, 5'd4}) begin errors++; $display("FAIL basic_payload: got %h want %h", {out_exop, out_offset, out_dest}, {8'h0D, 32'h10, 5'd4}); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_fwd_priority();
        in_valid = 1; in_src_addr = {5'd0, 5'd5}; in_src_sel = {2'b00, 2'b01};
        rf_rdata = {32'h0, 32'h7777}; fwd_we = 2'b11; fwd_dest = {5'd5, 5'd5}; fwd_avail = 2'b11;
        fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
        @(negedge clk);
        checks++; if (out_src !== {32'h0, 32'hAAAA}) begin errors++; $display("FAIL fwd_youngest: got %h want %h", out_src, {32'h0, 32'hAAAA}); end
        fwd_we = 2'b10;
        @(negedge clk);
        checks++; if (out_src !== {32'h0, 32'hBBBB}) begin errors++; $display("FAIL fwd_older: got %h want %h", out_src, {32'h0, 32'hBBBB}); end
        fwd_we = 2'b11; fwd_avail = 2'b10;
        #1;
        checks++; if ({hazard, in_ready} !== 2'b10) begin errors++; $display("FAIL fwd_young_unavail: got %b want 10", {hazard, in_ready}); end
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL fwd_cnt: got %0d want 1", stall_cnt); end
        idle();
    endtask

    task automatic test_load_use();
        in_valid = 1; in_src_addr = {5'd7, 5'd0}; in_src_sel = {2'b01, 2'b00};
        rf_rdata = {32'h1111, 32'h0}; fwd_we = 2'b01; fwd_dest = {5'd0, 5'd7}; fwd_avail = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({hazard, in_ready} !== 2'b10) begin errors++; $display("FAIL lu_stall%0d: got %b want 10", k, {hazard, in_ready}); end
            @(negedge clk);
            checks++; if (stall_cnt !== 4'(2 + k)) begin errors++; $display("FAIL lu_cnt%0d: got %0d want %0d", k, stall_cnt, 2 + k); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_no_capture: got %b want 0", out_valid); end
        fwd_avail = 2'b01; fwd_data = {32'h0, 32'h55};
        #1;
        checks++; if ({hazard, in_ready} !== 2'b01) begin errors++; $display("FAIL lu_release: got %b want 01", {hazard, in_ready}); end
        @(negedge clk);
        idle();
        checks++; if (out_src !== {32'h55, 32'h0} || out_valid !== 1'b1) begin errors++; $display("FAIL lu_src: got %b/%h want 1/%h", out_valid, out_src, {32'h55, 32'h0}); end
        checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL lu_cnt_hold: got %0d want 4", stall_cnt); end
    endtask

    task automatic test_zero_reg();
        in_valid = 0; in_src_addr = {5'd0, 5'd7}; in_src_sel = {2'b00, 2'b01};
        fwd_we = 2'b01; fwd_dest = {5'd0, 5'd7}; fwd_avail = 2'b00;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL zero_gated: got %b want 0", hazard); end
        in_valid = 1; in_src_addr = {5'd9, 5'd0}; in_src_sel = {2'b11, 2'b01};
        fwd_dest = {5'd0, 5'd0}; rf_rdata = {32'hDEAD, 32'hBEEF}; in_imm = 32'h77;
        #1;
        checks++; if ({hazard, in_ready} !== 2'b01) begin errors++; $display("FAIL zero_nohaz: got %b want 01", {hazard, in_ready}); end
        @(negedge clk);
        idle();
        checks++; if (out_src !== 64'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL zero_src: got %b/%h want 1/0", out_valid, out_src); end
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        in_valid = 1; in_exop = 8'h22; in_src_addr = {5'd0, 5'd6}; in_src_sel = {2'b10, 2'b01};
        rf_rdata = {32'h0, 32'h600D}; in_imm = 32'h1111; in_offset = 32'h40; in_dest = 5'd9;
        out_ready = 0;
        @(negedge clk);
        in_exop = 8'h33; rf_rdata = {32'h0, 32'h9999}; in_imm = 32'h2222; in_offset = 32'h80;
        in_dest = 5'd10;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({in_ready, hazard} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b want 00", k, {in_ready, hazard}); end
            @(negedge clk);
            checks++; if ({out_valid, out_exop, out_src, out_offset, out_dest} !== {1'b1, 8'h22, 32'h1111, 32'h600D, 32'h40, 5'd9}) begin
                errors++; $display("FAIL bp_hold%0d: got %h want %h", k, {out_valid, out_exop, out_src, out_offset, out_dest}, {1'b1, 8'h22, 32'h1111, 32'h600D, 32'h40, 5'd9});
            end
            checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL bp_cnt%0d: got %0d want 4", k, stall_cnt); end
        end
        flush = 1; out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        idle();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nocap: got %b want 0", out_valid); end
    endtask

    task automatic test_counter();
        in_valid = 1; in_src_addr = {5'd0, 5'd7}; in_src_sel = {2'b00, 2'b01};
        fwd_we = 2'b01; fwd_dest = {5'd0, 5'd7}; fwd_avail = 2'b00; cnt_clr = 1;
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr_prio: got %0d want 0", stall_cnt); end
        cnt_clr = 0; flush = 1;
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_flush: got %0d want 0", stall_cnt); end
        flush = 0;
        repeat (14) @(negedge clk);
        checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL cnt_14: got %0d want 14", stall_cnt); end
        repeat (6) @(negedge clk);
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat: got %0d want 15", stall_cnt); end
        cnt_clr = 1;
        @(negedge clk);
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_clr: got %0d want 0", stall_cnt); end
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        in_valid = 1; in_exop = 8'h5A; in_src_sel = {2'b10, 2'b10}; in_imm = 32'hABCD; out_ready = 0;
        @(negedge clk);
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b want 1", out_valid); end
        #2 rst_n = 0;
        #1;
        checks++; if ({out_valid, out_exop, out_src} !== 73'h0) begin errors++; $display("FAIL rst_async: got %h want 0", {out_valid, out_exop, out_src}); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_after: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fwd_priority();
        test_load_use();
        test_zero_reg();
        test_back_pressure();
        test_counter();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_operand_issue.md
Name: id_operand_issue

Overview:
- Parametrised successor to the single-cycle decode/forward stage; resolves NUM_SRC source operands per instruction.
- Per operand: zero, register file, immediate, or the youngest matching forwarding stage among FWD_STAGES.
- Detects load-use hazards and stalls via a valid/ready handshake.
- Holds the result in a registered ID/EX latch with flush support and a saturating hazard-stall counter.

Parameters:
- DATA_W, 32: operand/immediate width
- REG_AW, 5: register address width; register 0 is hard zero
- NUM_SRC, 2: source operands per instruction (1..4)
- FWD_STAGES, 2: forwarding sources; index 0 = youngest (EX), rising index = older (MEM, WB...)
- OP_W, 8: execute opcode width
- CNT_W, 16: stall counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_exop  in  OP_W  execute opcode
- in_src_addr  in  NUM_SRC*REG_AW  source register addresses, src i at [i*REG_AW +: REG_AW]
- in_src_sel  in  NUM_SRC*2  per source: 00 zero, 01 register, 10 immediate, 11 treated as zero
- in_imm  in  DATA_W  extended immediate
- in_offset  in  DATA_W  branch/memory offset, passed through
- in_dest  in  REG_AW  destination register
- rf_raddr  out  NUM_SRC*REG_AW  register-file read addresses = in_src_addr, combinational
- rf_rdata  in  NUM_SRC*DATA_W  register-file read data, same cycle
- fwd_we  in  FWD_STAGES  stage i will write fwd_dest[i]
- fwd_dest  in  FWD_STAGES*REG_AW  stage destinations
- fwd_avail  in  FWD_STAGES  stage i result already valid (0 = load in flight)
- fwd_data  in  FWD_STAGES*DATA_W  stage results
- flush  in  1  kill latched and incoming instruction
- out_valid  out  1  ID/EX latch holds instruction
- out_ready  in  1  execute consumes latch
- out_exop  out  OP_W  latched opcode
- out_src  out  NUM_SRC*DATA_W  latched resolved operands
- out_offset  out  DATA_W  latched offset
- out_dest  out  REG_AW  latched destination
- hazard  out  1  in_valid and unresolved hazard this cycle
- stall_cnt  out  CNT_W  saturating count of hazard cycles
- cnt_clr  in  1  synchronous clear of stall_cnt

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_exop=0, out_src=0, out_offset=0, out_dest=0, stall_cnt=0.
- Operand resolution, combinational per source i:
  - sel 00/11 gives 0; sel 10 gives in_imm.
  - sel 01 with addr 0 gives 0, never a hazard.
  - sel 01, addr nonzero: scan stages 0..FWD_STAGES-1; first j with fwd_we[j] && fwd_dest[j]==addr wins.
  - Winner with fwd_avail[j]=1 gives fwd_data[j]; fwd_avail[j]=0 raises a hazard for src i.
  - No match gives rf_rdata[i].
  - Older stages never override a younger match, even if the younger one is unavailable.
- hazard = in_valid && OR of per-source hazards (OR, not AND).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Capture when in_valid && in_ready: next cycle out_valid=1, outputs = resolved values. Latency = 1 cycle.
- If out_valid && out_ready && no capture: out_valid goes to 0.
- If out_valid && !out_ready: all out_* held stable; operands are not re-resolved.
- Flush beats capture and hold: next cycle out_valid=0, payload don't-care (keep previous values).
- stall_cnt:
  - cnt_clr has priority and sets it to 0.
  - Otherwise +1 each cycle hazard && !flush.
  - Saturates at 2^CNT_W-1, no wrap.
- Back-pressure alone (out_valid && !out_ready) is not counted.

Test Plan:
- ORI-like instruction: src0 sel=01 addr=3, rf_rdata0=0x0000_1234, src1 sel=10, imm=0x0000_00FF, no forwarding -> one cycle later out_valid=1, out_src0=0x1234, out_src1=0xFF.
- Double match: addr=5, stage0 (we, dest=5, avail, data=0xAAAA) and stage1 (dest=5, data=0xBBBB) -> out_src0=0xAAAA; with stage0 we=0 -> 0xBBBB.
- Load-use: stage0 dest=7 avail=0, src1 addr=7 -> hazard=1, in_ready=0, stall_cnt +1 per cycle. avail->1 with data=0x55 -> captured, out_src1=0x55.
- Zero register: addr=0 with stage0 dest=0 avail=0 -> no hazard, operand 0.
- Back-pressure: out_ready=0 for 3 cycles -> out_* stable, in_ready=0, stall_cnt unchanged. Then flush=1 with in_valid=1 -> out_valid=0 next cycle, nothing captured.
- Counter: CNT_W=4, 20 hazard cycles -> stall_cnt=15. cnt_clr -> 0. rst_n low mid-hold -> out_valid=0 immediately.
